jedro_1_ifu: RTL and testbench
==============================

# jedro_1_ifu

Instruction fetch unit for riscv-jedro-1: produces the instruction stream that the decoder consumes on its `instr_rdata`/`instr_next_avail`/`instr_next_en` interface. Keeps the PC and issues word reads to instruction memory over a req/gnt/rvalid bus. Buffers returned words in a small prefetch FIFO. Redirects and flushes on a jump request from the control unit.

## Interface
- `BOOT_ADDR`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `instr_req_o`  out  1  memory read request.
- `instr_addr_o`  out  32  word address of the request; bits [1:0] always 0.
- `instr_gnt_i`  in  1  request accepted this cycle.
- `instr_rvalid_i`  in  1  response data valid; responses return in request order.
- `instr_mem_rdata_i`  in  32  response data.
- `instr_rdata_o`  out  32  instruction at the FIFO head, to the decoder.
- `instr_pc_o`  out  32  PC of `instr_rdata_o`.
- `instr_next_avail_o`  out  1  FIFO non-empty.
- `instr_next_en_i`  in  1  decoder takes the head entry.
- `jmp_i`  in  1  redirect request from the control unit.
- `jmp_addr_i`  in  32  redirect target; bits [1:0] ignored (treated as 0).

## Operation
- Reset values: `instr_req_o`=0, `instr_addr_o`=`BOOT_ADDR`, `instr_next_avail_o`=0, `instr_rdata_o`=0, `instr_pc_o`=0. Internally: fetch PC=`BOOT_ADDR`, FIFO empty, outstanding=0, discard=0.
- Credit rule: assert `instr_req_o` only while count + outstanding < `FIFO_DEPTH`, using registered values. The FIFO can never overflow.
- Request stability: once raised, `instr_req_o` and `instr_addr_o` hold until `instr_gnt_i`. The only exception is `jmp_i`.
- On grant: fetch PC += 4 (wraps modulo 2^32); outstanding += 1.
- On `instr_rvalid_i`: outstanding −= 1.
  - If discard > 0: drop the word and decrement discard.
  - Otherwise: push {PC of that request, data} into the FIFO.
- Decoder handshake: a transfer occurs on a cycle where `instr_next_avail_o` & `instr_next_en_i`. The FIFO pops at that edge.
  - `instr_rdata_o` and `instr_pc_o` are stable while avail=1 and no transfer occurs.
  - `instr_rdata_o` and `instr_pc_o` are don't-care while avail=0.
- Simultaneous push and pop: allowed at any count, including full. Count is unchanged.
- `jmp_i` has priority over all other updates:
  - Fetch PC ← `jmp_addr_i`.
  - FIFO is cleared.
  - discard ← outstanding after this cycle's grant/rvalid updates.
  - An ungranted pending request is abandoned. A request granted in the same cycle counts as outstanding and is therefore discarded.
  - A decoder transfer in the `jmp_i` cycle is complete; the control unit ignores that instruction.
- Requests resume from the new target on the cycle after `jmp_i`. They are still credit-limited, with discard counted as outstanding.
- Back-to-back `jmp_i`: each one re-targets. discard accumulates correctly.
- Asynchronous reset mid-transfer: all state returns to reset values immediately. The memory side must also be reset, because no stale rvalid is tolerated.

## Timing
- First request: `instr_req_o`=1 in the first cycle after `rst_i` deasserts, with `instr_addr_o`=`BOOT_ADDR`.
- Fetch latency: grant in cycle N, rvalid earliest N+1, `instr_next_avail_o`=1 in cycle N+2. The FIFO is registered; there is no combinational path from `instr_mem_rdata_i` to the outputs.
- Throughput: with `FIFO_DEPTH`≥3, 1-cycle memory latency, and gnt/en tied high, one instruction per cycle is sustained.
- Redirect penalty: `jmp_i` in cycle J; first target request in J+1; target instruction available no earlier than J+3.
- No combinational path from `instr_next_en_i` or `jmp_i` to `instr_req_o`/`instr_addr_o`. Both are registered.

## Structure
- `jedro_1_defines.v`: `DATA_WIDTH`, `ADDR_WIDTH`, default `BOOT_ADDR`, instruction word size (4).
- Sub-module `jedro_1_fifo`:
  - Synchronous FIFO, 64-bit entries {pc, instr}.
  - Parameter `DEPTH`.
  - Ports: push, pop, flush, full, empty, count.
  - Head data is read combinationally from a registered array.
- Top level holds the PC, outstanding/discard counters, the request register, and the credit check.

## Test plan
- Reset release, memory with 1-cycle latency returning addr^32'hA5A5_0000, decoder always ready → requests to 0x0,0x4,0x8…; instructions delivered in order with matching `instr_pc_o`; from steady state onward, one per cycle.
- Decoder holds `instr_next_en_i`=0 → exactly 4 requests granted, then `instr_req_o` stays 0. `instr_rdata_o`/`instr_pc_o` stay frozen at PC 0x0. Releasing en drains 0x0–0xC in order.
- Memory withholds gnt for 5 cycles → `instr_req_o`/`instr_addr_o`=0x0 stable throughout; no PC advance.
- 3 requests outstanding (latency 4), `jmp_i` with `jmp_addr_i`=0x103 → the 3 stale responses are dropped. Next request address is 0x100. First delivered instruction has `instr_pc_o`=0x100.
- `jmp_i` in the same cycle as a grant and a decoder transfer → the granted response is discarded and the transfer counts as complete. The next delivered PC is the target.
- `rst_i` asserted mid-stream with FIFO full → outputs return to reset values immediately, without waiting for a clock edge. After release, fetch restarts at `BOOT_ADDR`.

Source files
------------

// File: rtl/jedro_1_pkg.sv
// rtl/jedro_1_pkg.sv - shared widths, defaults and fetch entry type for the jedro_1 fetch unit
package jedro_1_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [ADDR_WIDTH-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  // One prefetch FIFO entry: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; the low address bits are dropped.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/jedro_1_fifo.sv
// rtl/jedro_1_fifo.sv - synchronous prefetch FIFO of {pc, instr} entries with flush
module jedro_1_fifo
  import jedro_1_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  fetch_entry_t     data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage and pointer registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/jedro_1_ifu.sv
// rtl/jedro_1_ifu.sv - instruction fetch unit: PC, credit-limited requests, prefetch and redirect
module jedro_1_ifu
  import jedro_1_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_mem_rdata_i,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_next_avail_o,
  input  logic                  instr_next_en_i,
  input  logic                  jmp_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                  req_q, req_d;
  logic [CNT_W-1:0]      out_q, out_d;
  logic [CNT_W-1:0]      discard_q, discard_d;
  logic [CNT_W-1:0]      level_d;
  logic [SUM_W-1:0]      credit_sum;

  logic                  granted;
  logic                  transfer;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  fetch_entry_t          fifo_in;
  fetch_entry_t          fifo_head;

  // A grant only counts against a request that is actually on the bus.
  assign granted  = req_q & instr_gnt_i;
  assign transfer = ~fifo_empty & instr_next_en_i;

  // Words arriving while stale responses are still owed, or during a redirect, are dropped.
  assign push    = instr_rvalid_i & (discard_q == '0) & ~jmp_i & (~fifo_full | transfer);
  assign fifo_in = '{pc: resp_pc_q, instr: instr_mem_rdata_i};

  assign instr_req_o        = req_q;
  assign instr_addr_o       = pc_q;
  assign instr_next_avail_o = ~fifo_empty;
  assign instr_rdata_o      = fifo_head.instr;
  assign instr_pc_o         = fifo_head.pc;

  // Next fetch PC, response PC, in-flight bookkeeping and request credit.
  // resp_pc tracks the PC of the next response that will be kept, so it only advances on push.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    discard_d = discard_q;
    out_d     = out_q + CNT_W'(granted) - CNT_W'(instr_rvalid_i);
    level_d   = fifo_count + CNT_W'(push) - CNT_W'(transfer);

    if (granted) begin
      pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
    end
    if (instr_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + ADDR_WIDTH'(INSTR_BYTES);
    end

    // Redirect: everything still in flight, including this cycle's grant, becomes stale.
    if (jmp_i) begin
      pc_d      = word_align(jmp_addr_i);
      resp_pc_d = word_align(jmp_addr_i);
      discard_d = out_d;
      level_d   = '0;
    end

    // Credit is judged on the state the request will see, so a raised request never overfills.
    credit_sum = SUM_W'(level_d) + SUM_W'(out_d);
    req_d      = (credit_sum < SUM_W'(FIFO_DEPTH));
  end

  // Fetch state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= BOOT_ADDR;
      resp_pc_q <= BOOT_ADDR;
      req_q     <= 1'b0;
      out_q     <= '0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      req_q     <= req_d;
      out_q     <= out_d;
      discard_q <= discard_d;
    end
  end

  jedro_1_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (fifo_in),
    .pop_i   (transfer),
    .flush_i (jmp_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_jedro_1_ifu.sv
// tb/tb_jedro_1_ifu.sv - self-checking bench for jedro_1_ifu with memory and stream model
module tb_jedro_1_ifu;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam logic [31:0] SIG   = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_mem_rdata_i = '0;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic        instr_next_avail_o;
  logic        instr_next_en_i = 1'b0;
  logic        jmp_i = 1'b0;
  logic [31:0] jmp_addr_i = '0;

  jedro_1_ifu #(
    .BOOT_ADDR  (BOOT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .instr_req_o        (instr_req_o),
    .instr_addr_o       (instr_addr_o),
    .instr_gnt_i        (instr_gnt_i),
    .instr_rvalid_i     (instr_rvalid_i),
    .instr_mem_rdata_i  (instr_mem_rdata_i),
    .instr_rdata_o      (instr_rdata_o),
    .instr_pc_o         (instr_pc_o),
    .instr_next_avail_o (instr_next_avail_o),
    .instr_next_en_i    (instr_next_en_i),
    .jmp_i              (jmp_i),
    .jmp_addr_i         (jmp_addr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          ready;
    bit          stale;
  } mreq_t;

  typedef struct {
    bit          en;
    bit          req;
    logic [31:0] addr;
    bit          avail;
    logic [31:0] pc;
  } vec_t;

  mreq_t       mq[$];
  vec_t        tbl[10];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          live = 0;
  int          returned = 0;
  int          n_gnt = 0;
  int          n_xfer = 0;
  bit          prev_hold = 0;
  logic [31:0] exp_req_addr = BOOT;
  logic [31:0] exp_pc = BOOT;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i             = 1'b1;
    instr_gnt_i       = 1'b0;
    instr_rvalid_i    = 1'b0;
    instr_mem_rdata_i = '0;
    instr_next_en_i   = 1'b0;
    jmp_i             = 1'b0;
    jmp_addr_i        = '0;
    mq.delete();
    exp_req_addr = BOOT;
    exp_pc       = BOOT;
    live         = 0;
    returned     = 0;
    prev_hold    = 0;
    n_gnt        = 0;
    n_xfer       = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc   = 0;
  endtask

  // One bus cycle: memory responds, outputs are checked against the stream model, clock advances.
  task automatic cycle(input bit en, input bit jmp, input logic [31:0] jaddr, input bit gnt);
    bit          rv;
    bit          xfer;
    bit          granted;
    int          nstale;
    mreq_t       head;
    logic [31:0] tgt;
    rv = (mq.size() > 0);
    if (rv) rv = (mq[0].ready <= cyc);
    instr_gnt_i       = gnt;
    instr_rvalid_i    = rv;
    instr_mem_rdata_i = 32'hDEAD_BEEF;
    if (rv) instr_mem_rdata_i = mq[0].addr ^ SIG;
    instr_next_en_i = en;
    jmp_i           = jmp;
    jmp_addr_i      = jaddr;
    nstale = 0;
    foreach (mq[i]) if (mq[i].stale) nstale++;

    chk("avail", 32'(instr_next_avail_o), 32'(returned > 0));
    if (prev_hold) chk("req_hold", 32'(instr_req_o), 32'd1);
    if (instr_req_o) begin
      chk("req_addr", instr_addr_o, exp_req_addr);
      chk("credit", 32'((live + nstale) < DEPTH), 32'd1);
    end

    xfer    = instr_next_avail_o && en;
    granted = instr_req_o && gnt;
    if (xfer) begin
      chk("pc", instr_pc_o, exp_pc);
      chk("rdata", instr_rdata_o, exp_pc ^ SIG);
      exp_pc = exp_pc + 32'd4;
      live--;
      returned--;
      n_xfer++;
    end
    if (rv) begin
      head = mq.pop_front();
      if (!head.stale) returned++;
    end
    if (granted) begin
      mq.push_back('{addr: exp_req_addr, ready: cyc + mem_lat, stale: 1'b0});
      live++;
      exp_req_addr = exp_req_addr + 32'd4;
      n_gnt++;
    end
    prev_hold = instr_req_o && !gnt && !jmp;
    if (jmp) begin
      tgt          = {jaddr[31:2], 2'b00};
      exp_req_addr = tgt;
      exp_pc       = tgt;
      foreach (mq[i]) mq[i].stale = 1'b1;
      live     = 0;
      returned = 0;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic wait_avail(input string nm, input logic [31:0] want);
    bit found = 0;
    for (int i = 0; i < 25 && !found; i++) begin
      if (instr_next_avail_o) found = 1;
      else cycle(1'b1, 1'b0, 32'h0, 1'b1);
    end
    chk({nm, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      chk(nm, instr_pc_o, want);
      chk({nm, "_data"}, instr_rdata_o, want ^ SIG);
    end
  endtask

  initial begin
    int k;
    tbl[0] = '{en: 1'b1, req: 1'b1, addr: 32'h00, avail: 1'b0, pc: 32'h00};
    tbl[1] = '{en: 1'b1, req: 1'b1, addr: 32'h04, avail: 1'b0, pc: 32'h00};
    tbl[2] = '{en: 1'b1, req: 1'b1, addr: 32'h08, avail: 1'b1, pc: 32'h00};
    tbl[3] = '{en: 1'b1, req: 1'b1, addr: 32'h0C, avail: 1'b1, pc: 32'h04};
    tbl[4] = '{en: 1'b1, req: 1'b1, addr: 32'h10, avail: 1'b1, pc: 32'h08};
    tbl[5] = '{en: 1'b0, req: 1'b1, addr: 32'h14, avail: 1'b1, pc: 32'h0C};
    tbl[6] = '{en: 1'b1, req: 1'b1, addr: 32'h18, avail: 1'b1, pc: 32'h0C};
    tbl[7] = '{en: 1'b1, req: 1'b1, addr: 32'h1C, avail: 1'b1, pc: 32'h10};
    tbl[8] = '{en: 1'b1, req: 1'b1, addr: 32'h20, avail: 1'b1, pc: 32'h14};
    tbl[9] = '{en: 1'b1, req: 1'b1, addr: 32'h24, avail: 1'b1, pc: 32'h18};

    // reset values, then streaming with one decoder stall
    do_reset();
    mem_lat = 1;
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_addr", instr_addr_o, BOOT);
    chk("rst_avail", 32'(instr_next_avail_o), 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("tbl_req", 32'(instr_req_o), 32'(tbl[i].req));
      chk("tbl_addr", instr_addr_o, tbl[i].addr);
      chk("tbl_avail", 32'(instr_next_avail_o), 32'(tbl[i].avail));
      if (tbl[i].avail) begin
        chk("tbl_pc", instr_pc_o, tbl[i].pc);
        chk("tbl_rdata", instr_rdata_o, tbl[i].pc ^ SIG);
      end
      cycle(tbl[i].en, 1'b0, 32'h0, 1'b1);
    end

    // decoder never ready: credit stops requests at FIFO_DEPTH, head stays frozen
    do_reset();
    mem_lat = 1;
    repeat (13) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("hold_grants", 32'(n_gnt), 32'd4);
    chk("hold_req", 32'(instr_req_o), 32'd0);
    chk("hold_avail", 32'(instr_next_avail_o), 32'd1);
    chk("hold_pc", instr_pc_o, 32'h0);
    chk("hold_rdata", instr_rdata_o, SIG);
    repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold_drain", 32'(n_xfer >= 4), 32'd1);

    // grant withheld: request and address hold steady
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (5) begin
      chk("nognt_req", 32'(instr_req_o), 32'd1);
      chk("nognt_addr", instr_addr_o, BOOT);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
    end
    repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("nognt_resume", 32'(n_xfer > 0), 32'd1);

    // three stale responses in flight at latency 4, redirect to 0x103
    do_reset();
    mem_lat = 4;
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("jmp_outstanding", 32'(n_gnt), 32'd3);
    cycle(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    chk("jmp_req", 32'(instr_req_o), 32'd1);
    chk("jmp_addr", instr_addr_o, 32'h0000_0100);
    wait_avail("jmp_pc", 32'h0000_0100);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // redirect in the same cycle as a grant and a decoder transfer
    do_reset();
    mem_lat = 1;
    repeat (7) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("jsame_avail", 32'(instr_next_avail_o), 32'd1);
    chk("jsame_req", 32'(instr_req_o), 32'd1);
    k = n_xfer;
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("jsame_xfer", 32'(n_xfer), 32'(k + 1));
    wait_avail("jsame_pc", 32'h0000_0200);
    repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // asynchronous reset with the FIFO full
    do_reset();
    mem_lat = 1;
    repeat (11) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("full_avail", 32'(instr_next_avail_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("arst_req", 32'(instr_req_o), 32'd0);
    chk("arst_addr", instr_addr_o, BOOT);
    chk("arst_avail", 32'(instr_next_avail_o), 32'd0);
    chk("arst_rdata", instr_rdata_o, 32'h0);
    chk("arst_pc", instr_pc_o, 32'h0);
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    wait_avail("restart_pc", BOOT);

    // randomized traffic against the stream model
    do_reset();
    repeat (600) begin
      mem_lat = $urandom_range(1, 3);
      cycle(($urandom % 4) != 0, ($urandom % 24) == 0, $urandom, ($urandom % 3) != 0);
    end
    k = n_xfer;
    mem_lat = 1;
    repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rand_drain", 32'(n_xfer > k), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
